// File: rtl/reg_bus_arbiter_if.sv
// Requester and register-bus signal bundle for reg_bus_arbiter.
// The slave view is the arbiter itself. The master view is everything around it:
// the requesters, plus the register file that supplies rdata.
interface reg_bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [8*NUM_REQ-1:0]  req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_rdata;
  logic [7:0]            addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rdata,
    output req_ready, rsp_valid, rsp_rdata, addr, wr_en, rd_en, wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rdata,
    input  req_ready, rsp_valid, rsp_rdata, addr, wr_en, rd_en, wdata, busy
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter that shares one GIC register bus among NUM_REQ requesters.
// Only one transaction is in flight at a time.
// A write takes two cycles: the grant and the strobe.
// A read also waits RD_LAT cycles, then spends one more cycle returning the data.
module reg_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_bus_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_last;
  logic [IDX_W-1:0]   cur_g;
  logic               cur_we;
  logic [CNT_W-1:0]   lat_cnt;
  logic [7:0]         addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rsp_rdata_q;
  logic               wr_en_q;
  logic               rd_en_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  logic               any_req;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic               sel_we;
  logic [7:0]         sel_addr;
  logic [31:0]        sel_wdata;
  int                 cand;

  // Search upward from the port after rr_last, with wrap, for the first valid request.
  // The scan uses constant indices only, so it unrolls into a plain priority mux.
  always_comb begin
    any_req    = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_last) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_req && (cand == i) && bus.req_valid[i]) begin
          any_req       = 1'b1;
          gnt_idx       = IDX_W'(i);
          gnt_onehot    = '0;
          gnt_onehot[i] = 1'b1;
        end
      end
    end
  end

  // Pull the winning requester's payload out of the flattened request vectors.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_we    = sel_we    | (bus.req_we[i] & gnt_onehot[i]);
      sel_addr  = sel_addr  | (bus.req_addr[8*i +: 8]   & {8{gnt_onehot[i]}});
      sel_wdata = sel_wdata | (bus.req_wdata[32*i +: 32] & {32{gnt_onehot[i]}});
    end
  end

  // Transaction sequencer.
  // The bus and response outputs are registered, so each one appears in the cycle
  // of the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_last     <= IDX_W'(NUM_REQ - 1);
      cur_g       <= '0;
      cur_we      <= 1'b0;
      lat_cnt     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= ISSUE;
            cur_g       <= gnt_idx;
            cur_we      <= sel_we;
            rr_last     <= gnt_idx;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            wr_en_q     <= sel_we;
            rd_en_q     <= ~sel_we;
            rsp_valid_q <= sel_we ? gnt_onehot : '0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        ISSUE: begin
          wr_en_q     <= 1'b0;
          rd_en_q     <= 1'b0;
          rsp_valid_q <= '0;
          if (cur_we) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state   <= WAIT_RD;
            lat_cnt <= CNT_W'(RD_LAT);
          end
        end
        WAIT_RD: begin
          if (lat_cnt == CNT_W'(1)) begin
            rsp_rdata_q <= bus.rdata;
            rsp_valid_q <= NUM_REQ'(1) << cur_g;
            state       <= RESP;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) ? gnt_onehot : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter.
// dut1 uses RD_LAT=1 and dut3 uses RD_LAT=3; they share the clock and the reset.
module tb_reg_bus_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  reg_bus_arbiter_if #(.NUM_REQ(4)) if1 ();
  reg_bus_arbiter_if #(.NUM_REQ(4)) if3 ();

  reg_bus_arbiter #(.NUM_REQ(4), .RD_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  reg_bus_arbiter #(.NUM_REQ(4), .RD_LAT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic we, input logic [7:0] a, input logic [31:0] d);
    if1.req_we[i]            = we;
    if1.req_addr[8*i +: 8]   = a;
    if1.req_wdata[32*i +: 32] = d;
  endtask

  // Directed sequence covering writes, reads, rotation, reset abort and a longer read latency.
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    if1.req_valid = '0; if1.req_we = '0; if1.req_addr = '0; if1.req_wdata = '0; if1.rdata = '0;
    if3.req_valid = '0; if3.req_we = '0; if3.req_addr = '0; if3.req_wdata = '0; if3.rdata = '0;

    repeat (2) nextCycle();
    $display("[TB] reset state");
    checkOutput("rst_wr_en", {31'd0, if1.wr_en}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, if1.rd_en}, 32'd0);
    checkOutput("rst_busy", {31'd0, if1.busy}, 32'd0);
    checkOutput("rst_rsp_valid", {28'd0, if1.rsp_valid}, 32'd0);
    checkOutput("rst_addr", {24'd0, if1.addr}, 32'd0);
    checkOutput("rst_rsp_rdata", if1.rsp_rdata, 32'd0);
    rst_n = 1'b1;

    $display("[TB] single write from requester 2");
    nextCycle();
    applyStimulus(2, 1'b1, 8'h10, 32'hDEADBEEF);
    if1.req_valid = 4'b0100;
    #1;
    checkOutput("wr_ready", {28'd0, if1.req_ready}, 32'h4);
    checkOutput("wr_busy_c0", {31'd0, if1.busy}, 32'd0);
    nextCycle();
    if1.req_valid = '0;
    #1;
    checkOutput("wr_en_c1", {31'd0, if1.wr_en}, 32'd1);
    checkOutput("wr_rd_en_c1", {31'd0, if1.rd_en}, 32'd0);
    checkOutput("wr_addr_c1", {24'd0, if1.addr}, 32'h10);
    checkOutput("wr_wdata_c1", if1.wdata, 32'hDEADBEEF);
    checkOutput("wr_rsp_valid_c1", {28'd0, if1.rsp_valid}, 32'h4);
    checkOutput("wr_rsp_rdata_c1", if1.rsp_rdata, 32'd0);
    checkOutput("wr_ready_c1", {28'd0, if1.req_ready}, 32'd0);
    checkOutput("wr_busy_c1", {31'd0, if1.busy}, 32'd1);
    nextCycle();
    #1;
    checkOutput("wr_en_c2", {31'd0, if1.wr_en}, 32'd0);
    checkOutput("wr_rsp_valid_c2", {28'd0, if1.rsp_valid}, 32'd0);
    checkOutput("wr_busy_c2", {31'd0, if1.busy}, 32'd0);
    checkOutput("wr_addr_hold_c2", {24'd0, if1.addr}, 32'h10);

    $display("[TB] read from requester 0, RD_LAT=1");
    applyStimulus(0, 1'b0, 8'h04, 32'h0);
    if1.req_valid = 4'b0001;
    if1.rdata     = 32'hFFFFFFFF;
    #1;
    checkOutput("rd_ready_c0", {28'd0, if1.req_ready}, 32'h1);
    nextCycle();
    if1.req_valid = '0;
    if1.rdata     = 32'hBAD0BAD0;
    #1;
    checkOutput("rd_en_c1", {31'd0, if1.rd_en}, 32'd1);
    checkOutput("rd_wr_en_c1", {31'd0, if1.wr_en}, 32'd0);
    checkOutput("rd_addr_c1", {24'd0, if1.addr}, 32'h04);
    checkOutput("rd_busy_c1", {31'd0, if1.busy}, 32'd1);
    checkOutput("rd_rsp_valid_c1", {28'd0, if1.rsp_valid}, 32'd0);
    nextCycle();
    if1.rdata = 32'h000000A5;
    #1;
    checkOutput("rd_en_c2", {31'd0, if1.rd_en}, 32'd0);
    checkOutput("rd_busy_c2", {31'd0, if1.busy}, 32'd1);
    checkOutput("rd_rsp_valid_c2", {28'd0, if1.rsp_valid}, 32'd0);
    checkOutput("rd_addr_c2", {24'd0, if1.addr}, 32'h04);
    nextCycle();
    if1.rdata = 32'hCAFECAFE;
    #1;
    checkOutput("rd_rsp_valid_c3", {28'd0, if1.rsp_valid}, 32'h1);
    checkOutput("rd_rsp_rdata_c3", if1.rsp_rdata, 32'h000000A5);
    checkOutput("rd_busy_c3", {31'd0, if1.busy}, 32'd1);
    checkOutput("rd_ready_c3", {28'd0, if1.req_ready}, 32'd0);
    nextCycle();
    #1;
    checkOutput("rd_rsp_valid_c4", {28'd0, if1.rsp_valid}, 32'd0);
    checkOutput("rd_rsp_rdata_c4", if1.rsp_rdata, 32'd0);
    checkOutput("rd_busy_c4", {31'd0, if1.busy}, 32'd0);

    $display("[TB] round robin with all four requesters writing");
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    nextCycle();
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 8'h20 + 8'(i), 32'h1000 + 32'(i));
    if1.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput($sformatf("rr_ready_%0d", k), {28'd0, if1.req_ready}, 32'd1 << (k % 4));
      checkOutput($sformatf("rr_idle_wr_en_%0d", k), {31'd0, if1.wr_en}, 32'd0);
      nextCycle();
      #1;
      checkOutput($sformatf("rr_wr_en_%0d", k), {31'd0, if1.wr_en}, 32'd1);
      checkOutput($sformatf("rr_rsp_valid_%0d", k), {28'd0, if1.rsp_valid}, 32'd1 << (k % 4));
      checkOutput($sformatf("rr_addr_%0d", k), {24'd0, if1.addr}, 32'h20 + 32'(k % 4));
      nextCycle();
    end

    $display("[TB] rr_last=1 with requesters 0 and 3 pending");
    if1.req_valid = 4'b1001;
    #1;
    checkOutput("pri_first", {28'd0, if1.req_ready}, 32'h8);
    nextCycle();
    #1;
    checkOutput("pri_first_addr", {24'd0, if1.addr}, 32'h23);
    checkOutput("pri_first_rsp", {28'd0, if1.rsp_valid}, 32'h8);
    nextCycle();
    #1;
    checkOutput("pri_second", {28'd0, if1.req_ready}, 32'h1);
    nextCycle();
    if1.req_valid = '0;
    #1;
    checkOutput("pri_second_addr", {24'd0, if1.addr}, 32'h20);
    nextCycle();
    #1;
    checkOutput("pri_idle_busy", {31'd0, if1.busy}, 32'd0);

    $display("[TB] reset during WAIT_RD");
    applyStimulus(0, 1'b0, 8'h30, 32'h0);
    if1.req_valid = 4'b0001;
    #1;
    checkOutput("abort_ready", {28'd0, if1.req_ready}, 32'h1);
    nextCycle();
    if1.req_valid = '0;
    #1;
    checkOutput("abort_rd_en", {31'd0, if1.rd_en}, 32'd1);
    nextCycle();
    #1;
    checkOutput("abort_busy_wait", {31'd0, if1.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, if1.busy}, 32'd0);
    checkOutput("abort_addr", {24'd0, if1.addr}, 32'd0);
    checkOutput("abort_rsp_valid", {28'd0, if1.rsp_valid}, 32'd0);
    nextCycle();
    #1;
    checkOutput("abort_no_rsp", {28'd0, if1.rsp_valid}, 32'd0);
    checkOutput("abort_no_rdata", if1.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(0, 1'b1, 8'h40, 32'h0000AAAA);
    applyStimulus(1, 1'b1, 8'h41, 32'h0000BBBB);
    if1.req_valid = 4'b0011;
    #1;
    checkOutput("after_rst_ready", {28'd0, if1.req_ready}, 32'h1);
    nextCycle();
    if1.req_valid = '0;
    #1;
    checkOutput("after_rst_wr_en", {31'd0, if1.wr_en}, 32'd1);
    checkOutput("after_rst_addr", {24'd0, if1.addr}, 32'h40);
    checkOutput("after_rst_rsp", {28'd0, if1.rsp_valid}, 32'h1);

    $display("[TB] RD_LAT=3 read from requester 1");
    nextCycle();
    if3.req_we[1]        = 1'b0;
    if3.req_addr[15:8]   = 8'h08;
    if3.req_valid        = 4'b0010;
    if3.rdata            = 32'h11111111;
    #1;
    checkOutput("l3_ready", {28'd0, if3.req_ready}, 32'h2);
    nextCycle();
    if3.req_valid = '0;
    if3.rdata     = 32'h22222222;
    #1;
    checkOutput("l3_rd_en", {31'd0, if3.rd_en}, 32'd1);
    checkOutput("l3_addr", {24'd0, if3.addr}, 32'h08);
    nextCycle();
    if3.rdata = 32'h33333333;
    #1;
    checkOutput("l3_rsp_c2", {28'd0, if3.rsp_valid}, 32'd0);
    checkOutput("l3_rd_en_c2", {31'd0, if3.rd_en}, 32'd0);
    nextCycle();
    if3.rdata = 32'h44444444;
    #1;
    checkOutput("l3_rsp_c3", {28'd0, if3.rsp_valid}, 32'd0);
    nextCycle();
    if3.rdata = 32'h12345678;
    #1;
    checkOutput("l3_rsp_c4", {28'd0, if3.rsp_valid}, 32'd0);
    checkOutput("l3_rdata_c4", if3.rsp_rdata, 32'd0);
    nextCycle();
    if3.rdata = 32'h55555555;
    #1;
    checkOutput("l3_rsp_c5", {28'd0, if3.rsp_valid}, 32'h2);
    checkOutput("l3_rdata_c5", if3.rsp_rdata, 32'h12345678);
    checkOutput("l3_busy_c5", {31'd0, if3.busy}, 32'd1);
    nextCycle();
    #1;
    checkOutput("l3_rsp_c6", {28'd0, if3.rsp_valid}, 32'd0);
    checkOutput("l3_busy_c6", {31'd0, if3.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the single GIC register bus (addr[7:0], wr_en, rd_en, wdata[31:0], rdata[31:0]) among NUM_REQ requesters, e.g. CPU host, debug port and config loader.
- Arbitration is round-robin. Accepted requests are sequenced onto the bus as one-cycle wr_en or rd_en strobes.
- Read data is returned to the owning requester after a fixed bus read latency.
- Sits between the requester ports and the GIC register file.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- RD_LAT, 1, cycles from the rd_en strobe cycle to the cycle rdata is valid (1..4).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_we  input  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  input  8*NUM_REQ  flattened; slice i = [8i+7:8i].
- req_wdata  input  32*NUM_REQ  flattened; slice i = [32i+31:32i].
- req_ready  output  NUM_REQ  one-hot accept strobe.
- rsp_valid  output  NUM_REQ  one-hot completion pulse.
- rsp_rdata  output  32  read data; 0 for write completions.
- addr  output  8  bus address.
- wr_en  output  1  bus write strobe.
- rd_en  output  1  bus read strobe.
- wdata  output  32  bus write data.
- rdata  input  32  bus read data.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (async assert, sync deassert by clk): all outputs 0; state IDLE; rr_last = NUM_REQ-1, so requester 0 has first priority. Any in-flight transaction is dropped; no rsp_valid is issued for it.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_last+1 upward with wrap.
  - req_ready[g] is driven combinationally high in the same cycle.
  - On the clock edge, latch g, we, addr and wdata; set rr_last = g; go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE (exactly 1 cycle):
  - addr and wdata are driven from the latch.
  - Write: wr_en = 1. rsp_valid[g] = 1 with rsp_rdata = 0 in this same cycle. Next state IDLE.
  - Read: rd_en = 1. Next state WAIT_RD; the latency counter loads RD_LAT.
- WAIT_RD:
  - The counter decrements each cycle.
  - On the cycle the counter reaches 1, sample rdata into rsp_rdata, then go to RESP.
  - Net effect: rdata is sampled RD_LAT cycles after the ISSUE cycle.
  - addr is held stable; wr_en and rd_en are 0.
- RESP (1 cycle): rsp_valid[g] = 1 and rsp_rdata holds the sampled data. Next state IDLE.
- Outside ISSUE: addr and wdata hold their last values; wr_en = rd_en = 0. Outside a response cycle: rsp_rdata = 0.
- Throughput: a write takes 2 cycles (IDLE, ISSUE). A read takes RD_LAT+3 cycles.
- Only one transaction is outstanding at a time. wr_en and rd_en are never high together.
- A requester must hold req_valid and its payload until it sees req_ready. Dropping req_valid before grant is legal and has no effect.
- Simultaneous requests: the rotating priority guarantees each continuously requesting port is granted within NUM_REQ grants.
- A requester may raise a new req_valid in the same cycle it receives rsp_valid; it is eligible at the next IDLE.
- Single requester: it is granted back-to-back; rr_last wraps correctly.
- Reset asserted during WAIT_RD: rsp_valid stays 0; after release, arbitration restarts from requester 0.

Test Plan:
- Reset, then req_valid[2]=1, we=1, addr=0x10, wdata=0xDEADBEEF -> req_ready[2] in cycle 0. In cycle 1: wr_en=1, addr=0x10, wdata=0xDEADBEEF, rsp_valid[2]=1, rsp_rdata=0.
- Read, RD_LAT=1: req 0 reads addr=0x04, bus model returns 0x0000_00A5 → rd_en in cycle 1; rsp_valid[0]=1 with rsp_rdata=0xA5 in cycle 3; busy high in cycles 1-3.
- All 4 requesters hold writes continuously from reset → grant order 0,1,2,3,0,1; wr_en every second cycle.
- rr_last=1; req 0 and req 3 both valid → req 3 is granted first, then req 0.
- Reset pulsed during WAIT_RD of a read → no rsp_valid; all outputs 0 asynchronously; the next request from 0 is served normally.
- RD_LAT=3, read with rdata=0x12345678 applied exactly 3 cycles after rd_en → rsp_rdata=0x12345678. Rdata garbage on the other cycles is ignored.
